// File: rtl/unpool_upsampler.sv
// 2x nearest-neighbour upsampler: each pixel is emitted twice, then each row is replayed from a line buffer.
// Optional feature macro UNPOOL_LAST_EN adds out_last, which marks the final pixel of each output row.
module unpool_upsampler #(
    parameter int DATA_WIDTH = 16,
    parameter int W_IN       = 14,
    parameter int H_IN       = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_frame_done
`ifdef UNPOOL_LAST_EN
    ,
    output logic                  out_last
`endif
);

    localparam int CW = $clog2(W_IN);
    localparam int RW = (H_IN > 1) ? $clog2(H_IN) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(W_IN - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H_IN - 1);

    typedef enum logic {S_FILL, S_REPLAY} state_t;

    state_t                state;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  dup;
    logic                  row_empty;
    logic [DATA_WIDTH-1:0] lb [W_IN];

    logic          xfer;
    logic          accept;
    logic          at_last;
    logic [CW-1:0] wr_col;

    assign xfer    = out_valid && out_ready;
    assign at_last = (col == COL_LAST) && !row_empty;
    assign wr_col  = row_empty ? '0 : col + 1'b1;

    // Input is held off while the second copy of the row's last pixel is
    // presented: that transfer starts the replay, so no new pixel can land.
    assign in_ready = !rst && (state == S_FILL) &&
                      (!out_valid || (out_ready && dup && !at_last));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (accept) begin
            lb[wr_col] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_FILL;
            col            <= '0;
            row            <= '0;
            dup            <= 1'b0;
            row_empty      <= 1'b1;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_frame_done <= 1'b0;
        end else begin
            out_frame_done <= 1'b0;
            case (state)
                S_FILL: begin
                    if (xfer && dup && at_last) begin
                        state     <= S_REPLAY;
                        col       <= '0;
                        out_data  <= lb[0];
                        out_valid <= 1'b1;
                        dup       <= 1'b0;
                    end else if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        dup       <= 1'b0;
                        col       <= wr_col;
                        row_empty <= 1'b0;
                    end else if (xfer && !dup) begin
                        dup <= 1'b1;
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                    end
                end
                S_REPLAY: begin
                    if (xfer && !dup) begin
                        dup <= 1'b1;
                    end else if (xfer) begin
                        dup <= 1'b0;
                        if (col == COL_LAST) begin
                            out_valid <= 1'b0;
                            col       <= '0;
                            row_empty <= 1'b1;
                            state     <= S_FILL;
                            if (row == ROW_LAST) begin
                                row            <= '0;
                                out_frame_done <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col      <= col + 1'b1;
                            out_data <= lb[col + 1'b1];
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

`ifdef UNPOOL_LAST_EN
    // Rises when the first copy of the last column hands over to the second copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_last <= 1'b0;
        end else if (xfer && !dup && at_last) begin
            out_last <= 1'b1;
        end else if (xfer || accept) begin
            out_last <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_unpool_upsampler.sv
// Self-checking bench for unpool_upsampler: a directed vector table, a few hand-written sequences,
// and random traffic checked against a queue-based model of the expected output stream.
module tb_unpool_upsampler;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_frame_done;
`ifdef UNPOOL_LAST_EN
    logic          out_last;
`endif

    always #5 clk = ~clk;

    unpool_upsampler #(.DATA_WIDTH(DW), .W_IN(W), .H_IN(H)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_frame_done (out_frame_done)
`ifdef UNPOOL_LAST_EN
        ,
        .out_last       (out_last)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: every accepted pixel yields two beats; a completed row yields its replay.
    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
        logic          rep;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] row_buf [W];
    int            m_col, beats, pend_rep, rep_pops, tot_beats, fd_count;
    logic          fd_next, stall, acc;
    logic [DW-1:0] held;

    function automatic beat_t mk(input logic [DW-1:0] d, input logic l, input logic r);
        beat_t b;
        b.d = d; b.last = l; b.rep = r;
        return b;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_col = 0; beats = 0; pend_rep = 0; rep_pops = 0;
        fd_next = 1'b0; stall = 1'b0;
    endtask

    task automatic apply(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic rs);
        beat_t b;
        in_valid = iv; in_data = id; out_ready = ordy; rst = rs;
        #1;
        acc = 1'b0;
        if (rs) begin
            chk("in_ready_in_reset", in_ready, 0);
            stall = 1'b0;
        end else begin
            if (pend_rep > 0) chk("in_ready_during_replay", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", out_valid, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("out_data", out_data, b.d);
`ifdef UNPOOL_LAST_EN
                    chk("out_last", out_last, b.last);
`endif
                    if (b.rep) begin pend_rep--; rep_pops++; end
                    tot_beats++;
                    beats++;
                    if (beats == 2 * W * 2 * H) begin beats = 0; fd_next = 1'b1; end
                end
            end
            stall = out_valid && !out_ready;
            held  = out_data;
            if (in_valid && in_ready) begin
                acc = 1'b1;
                exp_q.push_back(mk(id, 1'b0, 1'b0));
                exp_q.push_back(mk(id, m_col == W - 1, 1'b0));
                row_buf[m_col] = id;
                m_col++;
                if (m_col == W) begin
                    m_col = 0;
                    for (int k = 0; k < W; k++) begin
                        exp_q.push_back(mk(row_buf[k], 1'b0, 1'b1));
                        exp_q.push_back(mk(row_buf[k], k == W - 1, 1'b1));
                    end
                    pend_rep += 2 * W;
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (rst) begin
            chk("reset_out_valid", out_valid, 0);
            chk("reset_out_data", out_data, 0);
            chk("reset_frame_done", out_frame_done, 0);
`ifdef UNPOOL_LAST_EN
            chk("reset_out_last", out_last, 0);
`endif
            model_reset();
        end else begin
            chk("frame_done", out_frame_done, fd_next);
            if (out_frame_done) fd_count++;
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held);
            end
        end
        fd_next = 1'b0;
    endtask

    task automatic do_reset();
        apply(1'b0, '0, 1'b1, 1'b1);
        advance();
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          ev;
        logic [DW-1:0] ed;
        logic          eir;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int idx, start;

        // One row 1..4 at full rate, then 9 held during the replay.
        tbl[0]  = '{1'b1, 16'd1, 1'b1, 1'b0, 16'd0, 1'b1};
        tbl[1]  = '{1'b1, 16'd2, 1'b1, 1'b1, 16'd1, 1'b0};
        tbl[2]  = '{1'b1, 16'd2, 1'b1, 1'b1, 16'd1, 1'b1};
        tbl[3]  = '{1'b1, 16'd3, 1'b1, 1'b1, 16'd2, 1'b0};
        tbl[4]  = '{1'b1, 16'd3, 1'b1, 1'b1, 16'd2, 1'b1};
        tbl[5]  = '{1'b1, 16'd4, 1'b1, 1'b1, 16'd3, 1'b0};
        tbl[6]  = '{1'b1, 16'd4, 1'b1, 1'b1, 16'd3, 1'b1};
        tbl[7]  = '{1'b1, 16'd9, 1'b1, 1'b1, 16'd4, 1'b0};
        tbl[8]  = '{1'b1, 16'd9, 1'b1, 1'b1, 16'd4, 1'b0};
        tbl[9]  = '{1'b1, 16'd9, 1'b1, 1'b1, 16'd1, 1'b0};
        tbl[10] = '{1'b1, 16'd9, 1'b1, 1'b1, 16'd1, 1'b0};
        tbl[11] = '{1'b1, 16'd9, 1'b1, 1'b1, 16'd2, 1'b0};
        tbl[12] = '{1'b1, 16'd9, 1'b1, 1'b1, 16'd2, 1'b0};
        tbl[13] = '{1'b1, 16'd9, 1'b1, 1'b1, 16'd3, 1'b0};
        tbl[14] = '{1'b1, 16'd9, 1'b1, 1'b1, 16'd3, 1'b0};
        tbl[15] = '{1'b1, 16'd9, 1'b1, 1'b1, 16'd4, 1'b0};
        tbl[16] = '{1'b1, 16'd9, 1'b1, 1'b1, 16'd4, 1'b0};
        tbl[17] = '{1'b1, 16'd9, 1'b1, 1'b0, 16'd0, 1'b1};
        tbl[18] = '{1'b1, 16'd9, 1'b1, 1'b1, 16'd9, 1'b0};

        tot_beats = 0;
        fd_count  = 0;
        model_reset();
        do_reset();

        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].iv, tbl[i].id, tbl[i].ordy, 1'b0);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].eir);
            if (tbl[i].ev || i == 0) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].ed);
            advance();
        end

        // Stalls: out_ready toggles every cycle; the 16 beats must still all arrive intact.
        do_reset();
        idx = 1;
        start = tot_beats;
        for (int c = 0; c < 60; c++) begin
            apply(idx <= 4, 16'(idx), (c % 2) == 0, 1'b0);
            if (acc) idx++;
            advance();
        end
        chk("stall_row_beats", tot_beats - start, 16);
        chk("stall_row_drained", exp_q.size(), 0);

        // Full frame: two rows, exactly one frame_done pulse after beat 32.
        do_reset();
        idx = 1;
        start = tot_beats;
        fd_count = 0;
        for (int c = 0; c < 60; c++) begin
            apply(idx <= 8, 16'(idx), 1'b1, 1'b0);
            if (acc) idx++;
            advance();
        end
        chk("frame_beats", tot_beats - start, 32);
        chk("frame_done_pulses", fd_count, 1);

        // Reset after the third replay beat, then a new row starting with 7.
        do_reset();
        idx = 1;
        for (int c = 0; c < 40 && rep_pops < 3; c++) begin
            apply(idx <= 4, 16'(idx), 1'b1, 1'b0);
            if (acc) idx++;
            advance();
        end
        chk("reached_third_replay_beat", rep_pops, 3);
        do_reset();
        apply(1'b1, 16'd7, 1'b1, 1'b0);
        chk("restart_in_ready", in_ready, 1);
        advance();
        chk("restart_out_valid", out_valid, 1);
        chk("restart_out_data", out_data, 7);
        idx = 8;
        for (int c = 0; c < 40; c++) begin
            apply(idx <= 10, 16'(idx), 1'b1, 1'b0);
            if (acc) idx++;
            advance();
        end
        chk("restart_row_drained", exp_q.size(), 0);

        // Random traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            apply(($urandom % 10) < 7, 16'($urandom), ($urandom % 10) < 7,
                  $urandom_range(0, 299) == 0);
            advance();
        end
        for (int c = 0; c < 200; c++) begin
            apply(1'b0, '0, 1'b1, 1'b0);
            advance();
        end
        chk("random_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
